ram_port_arbiter: RTL

Shares the dual-port RAM (one write port, one read port, 8-bit address, 8-bit data, 1-cycle registered read) between NUM_REQ requesters. Each cycle, independent round-robin arbiters grant at most one write and one read, drive the RAM ports, and return read data one cycle later tagged with the requester ID. The block sits between the requester agents and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_port_arbiter_rr_arbiter.sv | 52 +++++
 rtl/ram_port_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for ram_port_arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned NUM_REQ_MAX = 8;
    localparam int unsigned ID_W_MAX    = $clog2(NUM_REQ_MAX);

    typedef logic [ID_W_MAX-1:0] req_id_t;

    typedef struct packed {
        logic                  valid;
        req_id_t               id;
        logic [DATA_W_DEF-1:0] data;
    } rsp_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, rotating pointer held inside.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   cand;

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        ptr_d     = ptr_q;
        cand      = '0;
        // Search ascending from the pointer, wrapping at N-1.
        for (int unsigned off = 0; off < N; off++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(off);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (!gnt_valid && req[cand[PW-1:0]]) begin
                gnt_valid              = 1'b1;
                gnt_idx                = cand[PW-1:0];
                gnt[cand[PW-1:0]]      = 1'b1;
            end
        end
        if (gnt_valid) begin
            if (32'(gnt_idx) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM write port and one RAM read port among NUM_REQ requesters.
// Optional RAM_ARB_FWD_EN: forward same-cycle write data to a colliding read.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      ram_wr_enbl,
    output logic [ADDR_W-1:0]         ram_wr_addr,
    output logic [DATA_W-1:0]         ram_wr_data,
    output logic                      ram_rd_enbl,
    output logic [ADDR_W-1:0]         ram_rd_addr,
    input  logic [DATA_W-1:0]         ram_rd_data
);

    logic [NUM_REQ-1:0] wr_req, rd_req, wr_gnt, rd_gnt;
    logic               wr_valid, rd_valid;
    logic [ID_W-1:0]    wr_idx, rd_idx;
    logic               rd_pend_q;
    logic [ID_W-1:0]    rd_id_q;

    // Gate with reset so no grant or RAM access is presented while held in reset.
    assign wr_req = req_valid &  req_wr & {NUM_REQ{rst}};
    assign rd_req = req_valid & ~req_wr & {NUM_REQ{rst}};

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (wr_req),
        .gnt       (wr_gnt),
        .gnt_valid (wr_valid),
        .gnt_idx   (wr_idx)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (rd_req),
        .gnt       (rd_gnt),
        .gnt_valid (rd_valid),
        .gnt_idx   (rd_idx)
    );

    assign req_gnt = wr_gnt | rd_gnt;

    always_comb begin
        ram_wr_enbl = wr_valid;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_rd_enbl = rd_valid;
        ram_rd_addr = '0;
        if (wr_valid) begin
            ram_wr_addr = req_addr[wr_idx*ADDR_W +: ADDR_W];
            ram_wr_data = req_wdata[wr_idx*DATA_W +: DATA_W];
        end
        if (rd_valid) begin
            ram_rd_addr = req_addr[rd_idx*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            rd_pend_q <= rd_valid;
            if (rd_valid) begin
                rd_id_q <= rd_idx;
            end
        end
    end

    assign rsp_valid = rd_pend_q;
    assign rsp_id    = rd_id_q;

`ifdef RAM_ARB_FWD_EN
    logic              fwd_q;
    logic [DATA_W-1:0] fwd_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= wr_valid && rd_valid && (ram_wr_addr == ram_rd_addr);
            fwd_data_q <= ram_wr_data;
        end
    end

    assign rsp_data = !rd_pend_q ? '0 : (fwd_q ? fwd_data_q : ram_rd_data);
`else
    assign rsp_data = rd_pend_q ? ram_rd_data : '0;
`endif

endmodule
